move_executor: RTL and testbench

Sequencer that owns the board memory while the control FSM grants it the datapath slot (`memory_manage == 2'b10`). It performs two operations: board initialisation (all 64 squares written with the opening layout) and piece moves (read source and destination, write the piece to the destination, clear the source). It reports the captured piece so the control FSM can evaluate the winning condition.

---
 rtl/board_pkg.sv | 41 ++++
 rtl/move_executor_if.sv | 22 ++
 rtl/board_init_rom.sv | 32 +++
 rtl/move_executor.sv | 173 +++++++++++++++++
 tb/tb_move_executor.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the chess board memory sequencer: piece codes, FSM states
// and the square-address helper.
package board_pkg;

    localparam logic [3:0] EMPTY     = 4'd0;
    localparam logic [3:0] P0_PAWN   = 4'd1;
    localparam logic [3:0] P0_KNIGHT = 4'd2;
    localparam logic [3:0] P0_BISHOP = 4'd3;
    localparam logic [3:0] P0_ROOK   = 4'd4;
    localparam logic [3:0] P0_QUEEN  = 4'd5;
    localparam logic [3:0] P0_KING   = 4'd6;
    localparam logic [3:0] P1_PAWN   = 4'd7;
    localparam logic [3:0] P1_KNIGHT = 4'd8;
    localparam logic [3:0] P1_BISHOP = 4'd9;
    localparam logic [3:0] P1_ROOK   = 4'd10;
    localparam logic [3:0] P1_QUEEN  = 4'd11;
    localparam logic [3:0] P1_KING   = 4'd12;

    // Player 1 codes are the player 0 codes shifted by this amount.
    localparam logic [3:0] PLAYER_OFFSET = 4'd6;

    typedef enum logic [2:0] {
        StIdle,
        StInitWr,
        StRdSrc,
        StRdDst,
        StLatch,
        StWrDst,
        StWrSrc,
        StDone
    } state_e;

    function automatic logic [5:0] sq_addr(input logic [2:0] x, input logic [2:0] y);
        return {x, y};
    endfunction

    function automatic logic is_king(input logic [3:0] code);
        return (code == P0_KING) || (code == P1_KING);
    endfunction

endpackage

// File: rtl/move_executor_if.sv
// Board memory port: registered address/data/write-enable out, read data returning
// one cycle after the address.
interface move_executor_if;
    logic [5:0] mem_addr;
    logic [3:0] mem_wdata;
    logic       mem_we;
    logic [3:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/board_init_rom.sv
// Opening layout lookup: square index {x, y} to the piece code placed there at the
// start of a game.
module board_init_rom
    import board_pkg::*;
(
    input  logic [5:0] index,
    output logic [3:0] code
);

    logic [3:0] back_rank;

    always_comb begin
        case (index[2:0])
            3'd0, 3'd7: back_rank = P0_ROOK;
            3'd1, 3'd6: back_rank = P0_KNIGHT;
            3'd2, 3'd5: back_rank = P0_BISHOP;
            3'd3:       back_rank = P0_QUEEN;
            default:    back_rank = P0_KING;
        endcase
    end

    always_comb begin
        case (index[5:3])
            3'd0:    code = back_rank;
            3'd1:    code = P0_PAWN;
            3'd6:    code = P1_PAWN;
            3'd7:    code = back_rank + PLAYER_OFFSET;
            default: code = EMPTY;
        endcase
    end

endmodule

// File: rtl/move_executor.sv
// Board memory sequencer: writes the opening layout or executes one piece move while
// the datapath slot is granted, reporting the captured piece.
module move_executor
    import board_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   grant,
    input  logic                   init_board,
    input  logic                   start_move,
    input  logic [2:0]             piece_x,
    input  logic [2:0]             piece_y,
    input  logic [2:0]             move_x,
    input  logic [2:0]             move_y,
    move_executor_if.master        mem,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             captured_piece,
    output logic                   king_captured
);

    localparam logic [6:0] InitEnd = 7'd64;

    state_e     state_q, state_d;
    logic [6:0] idx_q, idx_d;
    logic [3:0] moving_q, moving_d;
    logic [3:0] captured_q, captured_d;
    logic       king_q, king_d;
    logic [5:0] addr_q, addr_d;
    logic [3:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       done_q, done_d;

    logic [5:0] src_addr;
    logic [5:0] dst_addr;
    logic       same_sq;
    logic [3:0] rom_code;

    assign src_addr = sq_addr(piece_x, piece_y);
    assign dst_addr = sq_addr(move_x, move_y);
    assign same_sq  = (src_addr == dst_addr);

    board_init_rom u_rom (
        .index (idx_q[5:0]),
        .code  (rom_code)
    );

    // Memory outputs are computed for the state being entered and registered on that edge.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        moving_d   = moving_q;
        captured_d = captured_q;
        king_d     = king_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (grant) begin
                    if (init_board) begin
                        state_d = StInitWr;
                        addr_d  = idx_q[5:0];
                        wdata_d = rom_code;
                        we_d    = 1'b1;
                        idx_d   = idx_q + 7'd1;
                    end else if (start_move) begin
                        state_d = StRdSrc;
                        addr_d  = src_addr;
                    end
                end
            end
            StInitWr: begin
                if (idx_q == InitEnd) begin
                    state_d = StDone;
                end else if (grant) begin
                    addr_d  = idx_q[5:0];
                    wdata_d = rom_code;
                    we_d    = 1'b1;
                    idx_d   = idx_q + 7'd1;
                end
            end
            StRdSrc: begin
                if (grant) begin
                    state_d = StRdDst;
                    addr_d  = dst_addr;
                end else begin
                    addr_d  = src_addr;
                end
            end
            StRdDst: begin
                if (grant) begin
                    state_d  = StLatch;
                    moving_d = mem.mem_rdata;
                end else begin
                    state_d = StRdSrc;
                    addr_d  = src_addr;
                end
            end
            StLatch: begin
                if (!grant) begin
                    state_d = StRdSrc;
                    addr_d  = src_addr;
                end else if (same_sq) begin
                    state_d    = StDone;
                    captured_d = EMPTY;
                    king_d     = 1'b0;
                end else begin
                    state_d    = StWrDst;
                    captured_d = mem.mem_rdata;
                    king_d     = is_king(mem.mem_rdata);
                    addr_d     = dst_addr;
                    wdata_d    = moving_q;
                    we_d       = 1'b1;
                end
            end
            StWrDst: begin
                if (grant) begin
                    state_d = StWrSrc;
                    addr_d  = src_addr;
                    wdata_d = EMPTY;
                    we_d    = 1'b1;
                end
            end
            StWrSrc: begin
                if (grant) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                idx_d   = '0;
                done_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            moving_q   <= EMPTY;
            captured_q <= EMPTY;
            king_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            moving_q   <= moving_d;
            captured_q <= captured_d;
            king_q     <= king_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            done_q     <= done_d;
        end
    end

    assign mem.mem_addr   = addr_q;
    assign mem.mem_wdata  = wdata_q;
    assign mem.mem_we     = we_q;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign captured_piece = captured_q;
    assign king_captured  = king_q;

endmodule

// File: tb/tb_move_executor.sv
// Directed bench for move_executor with a behavioural board memory and write log.
module tb_move_executor;
    import board_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       grant = 1'b0;
    logic       init_board = 1'b0;
    logic       start_move = 1'b0;
    logic [2:0] piece_x = '0;
    logic [2:0] piece_y = '0;
    logic [2:0] move_x = '0;
    logic [2:0] move_y = '0;
    logic       busy;
    logic       done;
    logic [3:0] captured_piece;
    logic       king_captured;

    move_executor_if mem_if ();

    move_executor dut (
        .clk            (clk),
        .reset          (reset),
        .grant          (grant),
        .init_board     (init_board),
        .start_move     (start_move),
        .piece_x        (piece_x),
        .piece_y        (piece_y),
        .move_x         (move_x),
        .move_y         (move_y),
        .mem            (mem_if),
        .busy           (busy),
        .done           (done),
        .captured_piece (captured_piece),
        .king_captured  (king_captured)
    );

    always #5 clk = ~clk;

    // Board memory with a backdoor write port for preloading.
    logic [3:0] board [0:63];
    logic       bk_we = 1'b0;
    logic [5:0] bk_addr = '0;
    logic [3:0] bk_data = '0;

    always @(posedge clk) begin
        if (mem_if.mem_we) board[mem_if.mem_addr] <= mem_if.mem_wdata;
        else if (bk_we) board[bk_addr] <= bk_data;
        mem_if.mem_rdata <= board[mem_if.mem_addr];
    end

    logic [9:0] wlog [0:1023];
    int         wcount = 0;

    always @(posedge clk) begin
        if (mem_if.mem_we) begin
            wlog[wcount[9:0]] <= {mem_if.mem_addr, mem_if.mem_wdata};
            wcount <= wcount + 1;
        end
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    logic       we_hist [0:255];
    logic [5:0] addr_hist [0:255];

    task automatic preload(input logic [5:0] a, input logic [3:0] d);
        @(negedge clk);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        @(posedge clk);
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    task automatic set_move(input logic [2:0] sx, input logic [2:0] sy,
                            input logic [2:0] dx, input logic [2:0] dy);
        piece_x = sx; piece_y = sy; move_x = dx; move_y = dy;
    endtask

    // Issues a request sampled at edge N; lat = edges after N until done is seen, -1 on timeout.
    task automatic run_op(input logic do_init, input logic do_move, input int drop_at,
                          input int drop_len, output int lat);
        int cnt;
        bit got;
        @(negedge clk);
        grant = 1'b1; init_board = do_init; start_move = do_move;
        @(posedge clk);
        @(negedge clk);
        init_board = 1'b0; start_move = 1'b0;
        cnt = 0; got = 0;
        while (!got && cnt < 200) begin
            we_hist[cnt]   = mem_if.mem_we;
            addr_hist[cnt] = mem_if.mem_addr;
            grant = !(cnt >= drop_at && cnt < drop_at + drop_len);
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (done === 1'b1) got = 1;
        end
        grant = 1'b1;
        lat = got ? cnt : -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_we} !== 11'd0) begin
            n_bad++; $display("FAIL reset_mem_outputs: got %h want 000", {mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_we});
        end
        n_cmp++; if ({busy, done, captured_piece, king_captured} !== 7'd0) begin
            n_bad++; $display("FAIL reset_status: got %b want 0000000", {busy, done, captured_piece, king_captured});
        end
        reset = 1'b0;
    endtask

    task automatic test_no_grant();
        bit seen_busy;
        seen_busy = 0;
        @(negedge clk);
        grant = 1'b0; init_board = 1'b1; start_move = 1'b1;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (busy !== 1'b0 || mem_if.mem_we !== 1'b0) seen_busy = 1;
        end
        init_board = 1'b0; start_move = 1'b0; grant = 1'b1;
        n_cmp++; if (seen_busy) begin
            n_bad++; $display("FAIL no_grant_ignored: got busy/we activity, want none");
        end
    endtask

    task automatic test_init();
        int lat, wbase, bad_seq, bad_mid;
        wbase = wcount;
        run_op(1'b1, 1'b0, -1, 0, lat);
        n_cmp++; if (lat != 65) begin
            n_bad++; $display("FAIL init_latency: got %0d want 65", lat);
        end
        n_cmp++; if (wcount - wbase != 64) begin
            n_bad++; $display("FAIL init_write_count: got %0d want 64", wcount - wbase);
        end
        bad_seq = 0;
        for (int i = 0; i < 64; i++) if (wlog[(wbase + i) % 1024][9:4] !== i[5:0]) bad_seq++;
        n_cmp++; if (bad_seq != 0) begin
            n_bad++; $display("FAIL init_addr_order: got %0d out-of-order writes want 0", bad_seq);
        end
        n_cmp++; if (board[4] !== 4'd6) begin
            n_bad++; $display("FAIL init_addr4: got %0d want 6", board[4]);
        end
        n_cmp++; if (board[60] !== 4'd12) begin
            n_bad++; $display("FAIL init_addr60: got %0d want 12", board[60]);
        end
        n_cmp++; if ({board[0], board[3], board[8], board[48], board[63]} !== {4'd4, 4'd5, 4'd1, 4'd7, 4'd10}) begin
            n_bad++; $display("FAIL init_corners: got %h want 4517a", {board[0], board[3], board[8], board[48], board[63]});
        end
        bad_mid = 0;
        for (int i = 16; i < 48; i++) if (board[i] !== 4'd0) bad_mid++;
        n_cmp++; if (bad_mid != 0) begin
            n_bad++; $display("FAIL init_empty_rows: got %0d nonzero squares want 0", bad_mid);
        end
    endtask

    task automatic test_quiet_move();
        int lat, wbase;
        wbase = wcount;
        set_move(3'd1, 3'd4, 3'd3, 3'd4);
        run_op(1'b0, 1'b1, -1, 0, lat);
        n_cmp++; if (lat != 6) begin
            n_bad++; $display("FAIL quiet_latency: got %0d want 6", lat);
        end
        n_cmp++; if ({addr_hist[0], addr_hist[1]} !== {6'd12, 6'd28}) begin
            n_bad++; $display("FAIL quiet_read_addrs: got %0d,%0d want 12,28", addr_hist[0], addr_hist[1]);
        end
        n_cmp++; if (wcount - wbase != 2 || wlog[wbase % 1024] !== {6'd28, 4'd1}
                     || wlog[(wbase + 1) % 1024] !== {6'd12, 4'd0}) begin
            n_bad++; $display("FAIL quiet_writes: got n=%0d %h %h want 2 1c1 0c0", wcount - wbase,
                              wlog[wbase % 1024], wlog[(wbase + 1) % 1024]);
        end
        n_cmp++; if ({captured_piece, king_captured} !== 5'd0) begin
            n_bad++; $display("FAIL quiet_captured: got %0d/%b want 0/0", captured_piece, king_captured);
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin
            n_bad++; $display("FAIL quiet_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_king_capture();
        int lat;
        preload(6'd60, 4'd12);
        preload(6'd36, 4'd5);
        set_move(3'd4, 3'd4, 3'd7, 3'd4);
        run_op(1'b0, 1'b1, -1, 0, lat);
        n_cmp++; if (lat != 6) begin
            n_bad++; $display("FAIL king_latency: got %0d want 6", lat);
        end
        n_cmp++; if (captured_piece !== 4'd12 || king_captured !== 1'b1) begin
            n_bad++; $display("FAIL king_captured: got %0d/%b want 12/1", captured_piece, king_captured);
        end
        n_cmp++; if (board[60] !== 4'd5 || board[36] !== 4'd0) begin
            n_bad++; $display("FAIL king_board: got %0d,%0d want 5,0", board[60], board[36]);
        end
    endtask

    task automatic test_reset_mid_init();
        @(negedge clk);
        grant = 1'b1; init_board = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init_board = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (mem_if.mem_addr !== 6'd20 || busy !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_index: got addr %0d busy %b want 20 1", mem_if.mem_addr, busy);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if ({mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_we, busy, done,
                      captured_piece, king_captured} !== 18'd0) begin
            n_bad++; $display("FAIL rst_mid_outputs: got %h want 0", {mem_if.mem_addr, mem_if.mem_wdata,
                              mem_if.mem_we, busy, done, captured_piece, king_captured});
        end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_idle: got busy %b want 0", busy);
        end
    endtask

    task automatic test_priority();
        int lat, wbase;
        wbase = wcount;
        set_move(3'd0, 3'd0, 3'd7, 3'd7);
        run_op(1'b1, 1'b1, -1, 0, lat);
        n_cmp++; if (lat != 65 || wcount - wbase != 64) begin
            n_bad++; $display("FAIL prio_init_runs: got lat %0d writes %0d want 65 64", lat, wcount - wbase);
        end
        n_cmp++; if (board[0] !== 4'd4 || board[63] !== 4'd10 || board[60] !== 4'd12) begin
            n_bad++; $display("FAIL prio_board: got %0d,%0d,%0d want 4,10,12", board[0], board[63], board[60]);
        end
    endtask

    task automatic test_same_square();
        int lat, wbase;
        preload(6'd18, 4'd3);
        wbase = wcount;
        set_move(3'd2, 3'd2, 3'd2, 3'd2);
        run_op(1'b0, 1'b1, -1, 0, lat);
        n_cmp++; if (lat != 4) begin
            n_bad++; $display("FAIL same_latency: got %0d want 4", lat);
        end
        n_cmp++; if (wcount != wbase) begin
            n_bad++; $display("FAIL same_no_writes: got %0d writes want 0", wcount - wbase);
        end
        n_cmp++; if (captured_piece !== 4'd0 || board[18] !== 4'd3) begin
            n_bad++; $display("FAIL same_result: got cap %0d sq %0d want 0 3", captured_piece, board[18]);
        end
    endtask

    task automatic test_grant_latch();
        int lat, wbase;
        wbase = wcount;
        set_move(3'd1, 3'd1, 3'd2, 3'd1);
        run_op(1'b0, 1'b1, 2, 2, lat);
        n_cmp++; if (lat != 10) begin
            n_bad++; $display("FAIL glatch_latency: got %0d want 10", lat);
        end
        n_cmp++; if (addr_hist[3] !== 6'd9 || addr_hist[5] !== 6'd17) begin
            n_bad++; $display("FAIL glatch_restart: got %0d,%0d want 9,17", addr_hist[3], addr_hist[5]);
        end
        n_cmp++; if (board[17] !== 4'd1 || board[9] !== 4'd0 || wcount - wbase != 2) begin
            n_bad++; $display("FAIL glatch_board: got %0d,%0d n=%0d want 1,0 n=2", board[17], board[9], wcount - wbase);
        end
    endtask

    task automatic test_grant_wrdst();
        int lat;
        set_move(3'd6, 3'd0, 3'd5, 3'd0);
        run_op(1'b0, 1'b1, 3, 3, lat);
        n_cmp++; if (lat != 9) begin
            n_bad++; $display("FAIL gwr_latency: got %0d want 9", lat);
        end
        n_cmp++; if ({we_hist[3], we_hist[4], we_hist[5], we_hist[6], we_hist[7], we_hist[8]} !== 6'b100010) begin
            n_bad++; $display("FAIL gwr_we_pattern: got %b%b%b%b%b%b want 100010", we_hist[3], we_hist[4],
                              we_hist[5], we_hist[6], we_hist[7], we_hist[8]);
        end
        n_cmp++; if (board[40] !== 4'd7 || board[48] !== 4'd0) begin
            n_bad++; $display("FAIL gwr_board: got %0d,%0d want 7,0", board[40], board[48]);
        end
    endtask

    initial begin
        test_reset();
        test_no_grant();
        test_init();
        test_quiet_move();
        test_king_capture();
        test_reset_mid_init();
        test_priority();
        test_same_square();
        test_grant_latch();
        test_grant_wrdst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
